// File: rtl/checksum_pkg.sv
// Shared definitions for the streaming ones'-complement checksum engine.
//   LANE_WIDTH  : width of one checksum word
//   state_e     : engine FSM states
//   ones_fold16 : one ones'-complement fold step (low half + high half)
//   keep_mask   : expands one byte-keep bit into an 8-bit data mask
package checksum_pkg;

  localparam int unsigned LANE_WIDTH = 16;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFold1,
    StFold2,
    StDone
  } state_e;

  function automatic logic [31:0] ones_fold16(input logic [31:0] x);
    return {16'h0000, x[15:0]} + {16'h0000, x[31:16]};
  endfunction

  function automatic logic [7:0] keep_mask(input logic keep);
    return {8{keep}};
  endfunction

endpackage

// File: rtl/checksum_lane_adder.sv
// Combinational masked adder tree over the 16-bit lanes of one beat.
//   i_data : beat data, big-endian (first byte in the top bits)
//   i_keep : byte enables, bit i guards data bits [8i+7:8i]
//   o_sum  : plain binary sum of the masked lanes (no ones'-complement wrap)
module checksum_lane_adder
  import checksum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SUM_W      = LANE_WIDTH + $clog2(DATA_WIDTH / LANE_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_keep,
  output logic [SUM_W-1:0]        o_sum
);

  localparam int unsigned LANES  = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] w_masked;

  always_comb begin
    w_masked = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      w_masked[b*8 +: 8] = i_data[b*8 +: 8] & keep_mask(i_keep[b]);
    end
  end

  always_comb begin
    o_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      o_sum = o_sum + SUM_W'(w_masked[j*LANE_WIDTH +: LANE_WIDTH]);
    end
  end

endmodule

// File: rtl/checksum_stream_engine.sv
// Streaming Internet checksum engine (generate / verify) with packet framing.
//   clk, reset (async, active-low), enable (freeze when low)
//   seed, mode        : sampled with the first beat of a packet
//   in_data/in_keep/in_valid/in_last/in_ready : beat input handshake
//   out_checksum/out_ok/out_len/out_valid/out_ready : result handshake
module checksum_stream_engine
  import checksum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [15:0]             seed,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_keep,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [15:0]             out_checksum,
  output logic                    out_ok,
  output logic [15:0]             out_len,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned LANES     = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
  localparam int unsigned SUM_W     = LANE_WIDTH + $clog2(LANES);
  localparam int unsigned EXT_W     = ACC_WIDTH + 4;
  // Weight of a carry out of the accumulator, modulo 2^16-1: 2^ACC == 2^(ACC mod 16).
  // For the default 32-bit accumulator this is bit 0, the classic end-around carry.
  localparam int unsigned CARRY_POS = ACC_WIDTH % 16;

  state_e               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_mode;
  logic [15:0]          r_len;

  logic                 w_idle;
  logic                 w_accept;
  logic [SUM_W-1:0]     w_lane_sum;
  logic [ACC_WIDTH-1:0] w_base;
  logic [EXT_W-1:0]     w_raw;
  logic [EXT_W-1:0]     w_pass1;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [31:0]          w_fold;
  logic [4:0]           w_keep_cnt;
  logic [16:0]          w_len_sum;
  logic [15:0]          w_len_next;

  assign w_idle   = (r_state == StIdle);
  assign in_ready = reset & enable & (w_idle | (r_state == StAccum));
  assign w_accept = in_valid & in_ready;

  checksum_lane_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_W      (SUM_W)
  ) u_lane_adder (
    .i_data (in_data),
    .i_keep (in_keep),
    .o_sum  (w_lane_sum)
  );

  // First beat starts from the seed; later beats continue the running sum.
  assign w_base  = w_idle ? ACC_WIDTH'(seed) : r_acc;
  assign w_raw   = EXT_W'(w_base) + EXT_W'(w_lane_sum);
  assign w_pass1 = EXT_W'(w_raw[ACC_WIDTH-1:0])
                 + (EXT_W'(w_raw[EXT_W-1:ACC_WIDTH]) << CARRY_POS);
  // A second wrap absorbs the rare carry produced by the first one; it cannot overflow again.
  assign w_acc_next = w_pass1[ACC_WIDTH-1:0]
                    + (ACC_WIDTH'(w_pass1[EXT_W-1:ACC_WIDTH]) << CARRY_POS);

  assign w_fold = ones_fold16(32'(r_acc));

  always_comb begin
    w_keep_cnt = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      w_keep_cnt = w_keep_cnt + 5'(in_keep[b]);
    end
  end

  assign w_len_sum  = 17'(w_idle ? 16'h0000 : r_len) + 17'(w_keep_cnt);
  assign w_len_next = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
  assign out_len    = r_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_acc        <= '0;
      r_mode       <= 1'b0;
      r_len        <= '0;
      out_checksum <= '0;
      out_ok       <= 1'b0;
      out_valid    <= 1'b0;
    end else if (enable) begin
      unique case (r_state)
        StIdle, StAccum: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_len <= w_len_next;
            if (w_idle) begin
              r_mode <= mode;
            end
            r_state <= in_last ? StFold1 : StAccum;
          end
        end
        StFold1: begin
          r_acc   <= ACC_WIDTH'(w_fold);
          r_state <= StFold2;
        end
        StFold2: begin
          r_acc        <= ACC_WIDTH'(w_fold);
          out_checksum <= r_mode ? w_fold[15:0] : ~w_fold[15:0];
          out_ok       <= (w_fold[15:0] == 16'hFFFF);
          out_valid    <= 1'b1;
          r_state      <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_checksum_stream_engine.sv
// Self-checking bench for checksum_stream_engine (DATA_WIDTH = 32).
module tb_checksum_stream_engine;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] seed;
  logic        mode;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_checksum;
  logic        out_ok;
  logic [15:0] out_len;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pkt_data[$];
  logic [3:0]  pkt_keep[$];
  logic [15:0] m_ck;
  logic        m_ok;
  logic [15:0] m_len;

  checksum_stream_engine #(
    .DATA_WIDTH (32),
    .ACC_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .seed         (seed),
    .mode         (mode),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_checksum (out_checksum),
    .out_ok       (out_ok),
    .out_len      (out_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: lay out the kept bytes in stream order, pair them into 16-bit words,
  // sum with wide integers and fold until the result fits in 16 bits.
  task automatic model(input logic [15:0] sd, input logic md);
    longint unsigned s;
    longint unsigned len;
    logic [7:0] b0, b1;
    s   = sd;
    len = 0;
    for (int i = 0; i < pkt_data.size(); i++) begin
      for (int w = 0; w < 2; w++) begin
        b0 = pkt_keep[i][3-2*w] ? pkt_data[i][31-16*w -: 8] : 8'h00;
        b1 = pkt_keep[i][2-2*w] ? pkt_data[i][23-16*w -: 8] : 8'h00;
        s  = s + {b0, b1};
      end
      len = len + $countones(pkt_keep[i]);
    end
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    m_ok  = (s[15:0] == 16'hFFFF);
    m_ck  = md ? s[15:0] : ~s[15:0];
    m_len = (len > 65535) ? 16'hFFFF : len[15:0];
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_a();
    pkt_data = '{32'h9801331b, 32'h980e5e4b, 32'h0011000a, 32'ha08f2694, 32'h000a6262};
    pkt_keep = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  endtask

  task automatic run_packet(input string tag, input logic [15:0] sd, input logic md,
                            input int drop_at, input int stall);
    int cyc;
    model(sd, md);
    seed = sd;
    mode = md;
    for (int i = 0; i < pkt_data.size(); i++) begin
      if (i == drop_at) begin
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = pkt_data[i];
        in_keep  = pkt_keep[i];
        in_last  = (i == pkt_data.size() - 1);
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #1;
          check({tag, "_en_low_ready"}, 32'(in_ready), 32'd0);
        end
        enable = 1'b1;
      end
      send_beat(pkt_data[i], pkt_keep[i], i == pkt_data.size() - 1);
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    check({tag, "_checksum"}, 32'(out_checksum), 32'(m_ck));
    check({tag, "_ok"}, 32'(out_ok), 32'(m_ok));
    check({tag, "_len"}, 32'(out_len), 32'(m_len));
    for (int c = 0; c < stall; c++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ck"}, 32'(out_checksum), 32'(m_ck));
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    seed      = '0;
    mode      = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ck", 32'(out_checksum), 32'd0);
    check("rst_ok", 32'(out_ok), 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    reset = 1'b1;
    #1;

    // Reference packet in generate mode, with explicit expected values.
    load_a();
    run_packet("gen_a", 16'h0000, 1'b0, -1, 0);
    check("gen_a_const_ck", 32'(out_checksum), 32'h14DE);
    check("gen_a_const_len", 32'(out_len), 32'd20);

    // Same packet with its checksum appended, verify mode.
    load_a();
    pkt_data.push_back(32'h14de0000);
    pkt_keep.push_back(4'b1100);
    run_packet("ver_a", 16'h0000, 1'b1, -1, 0);
    check("ver_a_const_ck", 32'(out_checksum), 32'hFFFF);
    check("ver_a_const_ok", 32'(out_ok), 32'd1);
    check("ver_a_const_len", 32'(out_len), 32'd22);

    // Odd byte count.
    pkt_data = '{32'h01020300};
    pkt_keep = '{4'b1110};
    run_packet("odd", 16'h0000, 1'b0, -1, 0);
    check("odd_const_ck", 32'(out_checksum), 32'hFBFD);
    check("odd_const_len", 32'(out_len), 32'd3);

    // End-around carry needing the second fold.
    pkt_data = '{32'hffff0001};
    pkt_keep = '{4'hF};
    run_packet("carry", 16'hFFFF, 1'b0, -1, 0);
    check("carry_const_ck", 32'(out_checksum), 32'hFFFE);

    // Output backpressure for 5 cycles.
    load_a();
    run_packet("bp", 16'h0000, 1'b0, -1, 5);

    // Enable dropped for 3 cycles mid-packet.
    load_a();
    run_packet("en_drop", 16'h0000, 1'b0, 2, 0);
    check("en_drop_const_ck", 32'(out_checksum), 32'h14DE);

    // Reset mid-packet, then a clean packet must show no residue.
    seed = 16'h1234;
    mode = 1'b1;
    send_beat(32'hdeadbeef, 4'hF, 1'b0);
    send_beat(32'hcafef00d, 4'hF, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    load_a();
    run_packet("post_rst", 16'h0000, 1'b0, -1, 0);
    check("post_rst_const_ck", 32'(out_checksum), 32'h14DE);

    // Randomised packets: length, seed, mode, keep patterns, enable drops, backpressure.
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = $urandom_range(1, 8);
      pkt_data.delete();
      pkt_keep.delete();
      for (int i = 0; i < nb; i++) begin
        pkt_data.push_back($urandom);
        if (i == nb - 1 || $urandom_range(0, 4) == 0) pkt_keep.push_back(4'($urandom));
        else pkt_keep.push_back(4'hF);
      end
      run_packet("rand", 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1,
                 $urandom_range(0, 2));
    end

    // Length counter saturation on a very long packet.
    pkt_data.delete();
    pkt_keep.delete();
    for (int i = 0; i < 16400; i++) begin
      pkt_data.push_back($urandom);
      pkt_keep.push_back(4'hF);
    end
    run_packet("sat", 16'($urandom), 1'b0, -1, 0);
    check("sat_const_len", 32'(out_len), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
